// File: rtl/elevador_pkg.sv
// rtl/elevador_pkg.sv - shared floor constants and types for the elevator slice
package elevador_pkg;

    localparam int N_FLOORS_DEF = 4;
    localparam int FLOOR_IDX_W  = $clog2(N_FLOORS_DEF);

    typedef logic [N_FLOORS_DEF-1:0] floor_vec_t;
    typedef logic [FLOOR_IDX_W-1:0]  floor_idx_t;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - synchroniser, debouncer and rising-edge detect for one raw button
module btn_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   s;

    assign s  = sync_q[SYNC_STAGES-1];
    assign db = db_q;

    // press is combinational so the consumer latches on the same edge db flips
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d  = cnt_q;
        db_d   = db_q;
        press  = 1'b0;
        if (s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = s;
            cnt_d = '0;
            press = s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

endmodule

// File: rtl/call_request_latch.sv
// rtl/call_request_latch.sv - latches debounced cabin/hall presses into a per-floor pending vector
module call_request_latch
    import elevador_pkg::*;
#(
    parameter int N_FLOORS        = N_FLOORS_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_FLOORS-1:0]         cab_btn,
    input  logic [N_FLOORS-1:0]         hall_btn,
    input  logic [$clog2(N_FLOORS)-1:0] cur_floor,
    input  logic                        llego,
    input  logic                        puerta,
    input  logic                        emergencia,
    output logic [N_FLOORS-1:0]         piso,
    output logic                        any_pending,
    output logic                        req_above,
    output logic                        req_below,
    output logic                        req_here
);

    localparam int IDX_W = $clog2(N_FLOORS);

    logic [N_FLOORS-1:0] press_cab, press_hall;
    logic [N_FLOORS-1:0] cab_db_unused, hall_db_unused;
    logic [N_FLOORS-1:0] piso_q, piso_d;

    for (genvar g = 0; g < N_FLOORS; g++) begin : g_cond
        btn_conditioner #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cab (
            .clk  (clk),
            .reset(reset),
            .raw  (cab_btn[g]),
            .db   (cab_db_unused[g]),
            .press(press_cab[g])
        );
        btn_conditioner #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_hall (
            .clk  (clk),
            .reset(reset),
            .raw  (hall_btn[g]),
            .db   (hall_db_unused[g]),
            .press(press_hall[g])
        );
    end

    // Emergency beats service clear, which beats a new press on the same floor
    always_comb begin
        piso_d = piso_q;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (emergencia) begin
                piso_d[i] = 1'b0;
            end else if (llego && puerta && (cur_floor == IDX_W'(i))) begin
                piso_d[i] = 1'b0;
            end else if (press_cab[i] || press_hall[i]) begin
                piso_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            piso_q <= '0;
        end else begin
            piso_q <= piso_d;
        end
    end

    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        req_here  = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (piso_q[i]) begin
                if (IDX_W'(i) > cur_floor)  req_above = 1'b1;
                if (IDX_W'(i) < cur_floor)  req_below = 1'b1;
                if (IDX_W'(i) == cur_floor) req_here  = 1'b1;
            end
        end
    end

    assign piso        = piso_q;
    assign any_pending = |piso_q;

endmodule

// File: tb/tb_call_request_latch.sv
// tb/tb_call_request_latch.sv - directed bench with a behavioural pending-request model
module tb_call_request_latch;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] cab_btn = '0;
    logic [N-1:0] hall_btn = '0;
    logic [1:0]   cur_floor = '0;
    logic         llego = 1'b0;
    logic         puerta = 1'b0;
    logic         emergencia = 1'b0;
    logic [N-1:0] piso;
    logic         any_pending, req_above, req_below, req_here;

    int checks = 0;
    int errors = 0;

    call_request_latch #(
        .N_FLOORS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .cab_btn(cab_btn), .hall_btn(hall_btn),
        .cur_floor(cur_floor), .llego(llego), .puerta(puerta), .emergencia(emergencia),
        .piso(piso), .any_pending(any_pending), .req_above(req_above),
        .req_below(req_below), .req_here(req_here)
    );

    always #5 clk = ~clk;

    // Model: each button keeps a log of raw samples; the synchronised sample seen at
    // an edge is the raw value SYNC edges earlier, and the debounced level flips once
    // the last DC synchronised samples all disagree with it.
    bit [63:0]    hist [2*N];
    bit           mdb  [2*N];
    logic [N-1:0] mpiso;
    logic [N-1:0] mset;
    bit           all_diff;
    bit           raw_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2*N; b++) begin
                hist[b] = '0;
                mdb[b]  = 1'b0;
            end
            mpiso = '0;
        end else begin
            mset = '0;
            for (int b = 0; b < 2*N; b++) begin
                raw_b   = (b < N) ? cab_btn[b] : hall_btn[b-N];
                hist[b] = {hist[b][62:0], raw_b};
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (hist[b][SYNC+k] == mdb[b]) all_diff = 1'b0;
                if (all_diff) begin
                    if (!mdb[b]) mset[b % N] = 1'b1;
                    mdb[b] = !mdb[b];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (emergencia) mpiso[i] = 1'b0;
                else if (llego && puerta && int'(cur_floor) == i) mpiso[i] = 1'b0;
                else if (mset[i]) mpiso[i] = 1'b1;
            end
        end
    end

    logic [7:0] exp_out, act_out;
    always @(negedge clk) begin
        if (!reset) begin
            exp_out = {mpiso, (mpiso != 0), 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < N; i++) begin
                if (mpiso[i] && i > int'(cur_floor))  exp_out[2] = 1'b1;
                if (mpiso[i] && i < int'(cur_floor))  exp_out[1] = 1'b1;
                if (mpiso[i] && i == int'(cur_floor)) exp_out[0] = 1'b1;
            end
            act_out = {piso, any_pending, req_above, req_below, req_here};
            checks++;
            if (act_out !== exp_out) begin
                errors++;
                $display("FAIL model_cycle t=%0t got piso/any/above/below/here=%b expected %b",
                         $time, act_out, exp_out);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, exp_v);
        end
    endtask

    task automatic serve(input logic [1:0] f);
        cur_floor = f;
        llego = 1'b1;
        puerta = 1'b1;
        tick(1);
        llego = 1'b0;
        puerta = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_state", {piso, any_pending, req_above, req_below, req_here}, 8'b0);
        tick(3);
        reset = 1'b0;

        // basic latch: exactly 6 edges of latency
        cab_btn = 4'b0100;
        tick(5);
        chk("latch_not_early", {4'b0, piso}, 8'h00);
        tick(1);
        chk("latch_edge6", {4'b0, piso}, 8'h04);
        chk("latch_flags", {5'b0, any_pending, req_above, req_below}, 8'b110);
        cab_btn = '0;
        tick(8);
        serve(2'd2);
        chk("serve_floor2", {4'b0, piso}, 8'h00);

        // bounce rejection on hall button 1
        hall_btn[1] = 1'b1; tick(1);
        hall_btn[1] = 1'b0; tick(2);
        hall_btn[1] = 1'b1; tick(3);
        hall_btn[1] = 1'b0; tick(2);
        hall_btn[1] = 1'b1; tick(2);
        hall_btn[1] = 1'b0; tick(6);
        chk("bounce_reject", {4'b0, piso}, 8'h00);
        hall_btn[1] = 1'b1; tick(8);
        chk("bounce_then_hold", {4'b0, piso}, 8'h02);
        hall_btn[1] = 1'b0; tick(8);

        // service clear at floor 3 with floors 1 and 3 pending
        cab_btn[3] = 1'b1; tick(8);
        cab_btn[3] = 1'b0; tick(8);
        chk("pending_1010", {4'b0, piso}, 8'h0A);
        serve(2'd3);
        chk("clear_floor3", {4'b0, piso}, 8'h02);
        chk("clear_flags", {6'b0, req_below, req_here}, 8'b10);
        serve(2'd1);
        chk("clear_floor1", {4'b0, piso}, 8'h00);

        // simultaneous set at served floor 2 and set at floor 0
        cur_floor = 2'd2; llego = 1'b1; puerta = 1'b1;
        cab_btn = 4'b0101;
        tick(8);
        chk("set_clear_same_edge", {4'b0, piso}, 8'h01);
        cab_btn = '0; llego = 1'b0; puerta = 1'b0;
        tick(8);
        serve(2'd0);

        // held-button edge rule
        cab_btn[3] = 1'b1; tick(8);
        chk("held_latch", {4'b0, piso}, 8'h08);
        serve(2'd3);
        tick(10);
        chk("held_no_relatch", {4'b0, piso}, 8'h00);
        cab_btn[3] = 1'b0; tick(8);
        cab_btn[3] = 1'b1; tick(8);
        chk("repress_latch", {4'b0, piso}, 8'h08);
        chk("top_floor_no_above", {6'b0, req_above, req_here}, 8'b01);
        cab_btn = '0; tick(8);

        // emergency wipes everything and swallows presses
        cur_floor = 2'd0;
        cab_btn = 4'b1111; tick(8);
        cab_btn = '0; tick(8);
        chk("all_pending", {4'b0, piso}, 8'h0F);
        emergencia = 1'b1; tick(1);
        chk("emergency_clear", {4'b0, piso}, 8'h00);
        hall_btn = 4'b0110; tick(8);
        chk("emergency_ignores", {4'b0, piso}, 8'h00);
        emergencia = 1'b0; tick(8);
        chk("held_across_emerg", {4'b0, piso}, 8'h00);
        hall_btn = '0; tick(8);

        // asynchronous reset mid-press, released with the button still held
        cab_btn[1] = 1'b1; tick(8);
        chk("pre_reset_latch", {4'b0, piso}, 8'h02);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", {piso, any_pending, req_above, req_below, req_here}, 8'b0);
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("post_reset_not_early", {4'b0, piso}, 8'h00);
        tick(1);
        chk("post_reset_relatch", {4'b0, piso}, 8'h02);
        cab_btn = '0; tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/call_request_latch.md
Name: call_request_latch

Overview:
- Upstream stage of the floor-selection FSM. Turns raw cabin and hall push-buttons into a registered, per-floor pending-request vector (`piso`); that FSM and the direction controller consume it.
- Each button input is synchronised and debounced, and its rising edge is captured. A pending request stays latched until the car serves that floor.
- Also produces direction-hint flags relative to the current floor.

Parameters:
- N_FLOORS, 4, number of floors; one-hot width of all floor vectors.
- SYNC_STAGES, 2, flip-flops in each button synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the debounced level before the debounced level flips (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cab_btn  in  N_FLOORS  raw cabin floor buttons, asynchronous.
- hall_btn  in  N_FLOORS  raw hall call buttons, asynchronous; one per floor, direction-agnostic.
- cur_floor  in  $clog2(N_FLOORS)  binary index of the floor the car is at or last passed.
- llego  in  1  car is stopped level at cur_floor.
- puerta  in  1  door open (1) / closed (0).
- emergencia  in  1  emergency active.
- piso  out  N_FLOORS  registered pending-request vector; bit i = floor i requested.
- any_pending  out  1  |piso.
- req_above  out  1  any piso bit with index > cur_floor.
- req_below  out  1  any piso bit with index < cur_floor.
- req_here  out  1  piso[cur_floor].

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all of the following are 0:
  - synchroniser flops, debounce counters, debounced levels, piso;
  - therefore any_pending, req_above, req_below and req_here are also 0.
- Button conditioner (one per raw input, 2*N_FLOORS total):
  - Synchronised sample `s` is the last flop of the SYNC_STAGES chain.
  - Counter `cnt` has width $clog2(DEBOUNCE_CYCLES+1).
    - If s == db: cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1: db <= s and cnt <= 0.
    - Else: cnt <= cnt+1.
  - `press` is a 1-cycle indication, true on the edge where db goes 0->1.
- Latency: a raw input stable high from before edge 0 gives db = 1 and piso set at edge SYNC_STAGES + DEBOUNCE_CYCLES (edge 6 with defaults).
- Glitches and bounces shorter than DEBOUNCE_CYCLES synchronised cycles never change db.
- Per-floor request: set_i = press_cab[i] | press_hall[i]. The two sources merge into one bit.
- Per-floor clear: clr_i = llego & puerta & (cur_floor == i).
- Update of piso[i], in priority order:
  1. emergencia = 1 -> piso <= 0, and all presses in that cycle are discarded.
  2. clr_i -> piso[i] <= 0. Clear wins over a simultaneous set_i; a press at the floor being served is dropped.
  3. set_i -> piso[i] <= 1.
  4. Otherwise piso[i] holds.
- Sets and clears on different floors in the same cycle are independent.
- Requests are edge-triggered:
  - A button held through its own clear does not re-latch; it must be released (db -> 0) and pressed again.
  - Pressing an already-pending floor has no effect.
- Buttons keep being debounced while emergencia is high. A button held across emergencia de-assertion does not re-latch, because no new rising edge occurs.
- Reset released with a button held: db starts at 0, so the request latches after the normal latency.
- Flag outputs are combinational from piso and cur_floor only; there is no extra register stage.
  - cur_floor = 0 -> req_below = 0.
  - cur_floor = N_FLOORS-1 -> req_above = 0.
- cur_floor values >= N_FLOORS (non-power-of-2 N_FLOORS) match no floor: nothing clears, req_here = 0.

Decomposition:
- Shared package `elevador_pkg`:
  - constant N_FLOORS_DEF = 4;
  - FLOOR_IDX_W = $clog2(N_FLOORS_DEF);
  - typedef floor_vec_t (logic [N_FLOORS-1:0]);
  - typedef floor_idx_t.
- Sub-module `btn_conditioner`, parameters SYNC_STAGES and DEBOUNCE_CYCLES:
  - ports clk, reset, raw, outputs db and press;
  - instantiated in generate loops, N_FLOORS times for cab_btn and N_FLOORS times for hall_btn.

Test Plan:
- Basic latch: reset 3 cycles, then cab_btn = 0100 held. Required: piso = 0100 at edge 6 after the change and not before; any_pending = 1. With cur_floor = 0: req_above = 1, req_below = 0.
- Bounce rejection: hall_btn[1] toggles 1,0,1,0 with 1-3 cycle pulses. Required: piso stays 0000. Then held 4+ cycles -> piso = 0010.
- Service clear: piso = 1010, cur_floor = 3. Assert llego = 1, puerta = 1 for 1 cycle. Required: piso = 0010 next edge, req_below = 1, req_here = 0.
- Simultaneous set/clear: piso = 0000, cur_floor = 2, llego = puerta = 1. cab_btn[2] and cab_btn[0] debounced on the same edge. Required: piso = 0001.
- Held-button edge rule: cab_btn[3] held while floor 3 is served (piso[3] cleared). Required: piso[3] stays 0 while held; release 5 cycles then press again -> piso[3] = 1.
- Emergency and reset: piso = 1111, emergencia = 1 -> piso = 0000 next edge. Presses during emergencia are ignored. Assert reset mid-press -> all outputs 0 immediately, asynchronously. Release reset with the button still held -> re-latched 6 edges later.
